// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the RV32 multicycle controller and decoder.
package riscv_ctrl_pkg;

  localparam int unsigned STATE_W  = 3;
  localparam int unsigned ERR_W    = 2;
  localparam int unsigned OPCODE_W = 7;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } ctrl_state_t;

  localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
  localparam logic [ERR_W-1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [OPCODE_W-1:0] OPC_INVALID = 7'b0000000;
  localparam logic [OPCODE_W-1:0] OPC_LUI     = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPC_JAL     = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPC_JALR    = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPC_LOAD    = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE   = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_OP      = 7'b0110011;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory-ack wait counter: flags the TIMEOUT_CYC-th consecutive pending request cycle.
module ctrl_wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic pending,
  output logic expired_c
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WCNT_W-1:0] cnt_q, cnt_d;

  // cnt_q counts request cycles already spent in the current wait state
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (pending) begin
      cnt_d = cnt_q + WCNT_W'(1);
    end
  end

  assign expired_c = pending && (cnt_q == WCNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multicycle RV32 sequencer: FETCH/DECODE/EXEC/MEM/WB with illegal-opcode trap.
// Define CTRL_TIMEOUT_EN to add the memory-ack timeout trap.
module riscv_mc_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             err_clr,
  input  logic [6:0]       opcode,
  input  logic             alu_instr,
  input  logic             branch_instr,
  input  logic             load_instr,
  input  logic             store_instr,
  input  logic             branch_taken,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dec_go,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             alu_en,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] instret
);

  ctrl_state_t       state_q, state_d;
  logic              imem_req_q, imem_req_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic              alu_en_q, alu_en_d;
  logic              rf_we_q, rf_we_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [ERR_W-1:0]  err_code_q, err_code_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic fetch_ack_c, mem_ack_c, retire_c, pc_sel_c, timeout_c;
  logic unused_c;

  // Acks only count while the matching request is actually raised
  assign fetch_ack_c = imem_req_q & imem_ack;
  assign mem_ack_c   = dmem_req_q & dmem_ack;

`ifdef CTRL_TIMEOUT_EN
  logic wait_start_c;
  assign wait_start_c = (state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM));

  ctrl_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (wait_start_c),
    .pending   (imem_req_q | dmem_req_q),
    .expired_c (timeout_c)
  );
  assign unused_c = alu_instr;
`else
  assign timeout_c = 1'b0;
  assign unused_c  = ^{alu_instr, 32'(TIMEOUT_CYC)};
`endif

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    retire_c   = 1'b0;
    pc_sel_c   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (fetch_ack_c) begin
          state_d = ST_DECODE;
        end else if (timeout_c) begin
          state_d    = ST_TRAP;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (opcode == OPC_INVALID) begin
          state_d    = ST_TRAP;
          err_code_d = ERR_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (load_instr | store_instr) begin
          state_d = ST_MEM;
        end else if (branch_instr) begin
          retire_c = 1'b1;
          pc_sel_c = branch_taken;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ack_c) begin
          if (store_instr) retire_c = 1'b1;
          else             state_d  = ST_WB;
        end else if (timeout_c) begin
          state_d    = ST_TRAP;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_WB: begin
        retire_c = 1'b1;
      end
      ST_TRAP: begin
        if (err_clr) begin
          state_d    = ST_IDLE;
          err_code_d = ERR_NONE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        err_code_d = ERR_NONE;
      end
    endcase

    if (retire_c) state_d = halt_req ? ST_IDLE : ST_FETCH;

    instret_d  = retire_c ? (instret_q + CNT_W'(1)) : instret_q;

    // Moore outputs are registered from the next state so they line up with state_q
    imem_req_d = (state_d == ST_FETCH);
    dmem_req_d = (state_d == ST_MEM);
    dmem_we_d  = (state_d == ST_MEM) & store_instr;
    alu_en_d   = (state_d == ST_EXEC);
    rf_we_d    = (state_d == ST_WB);
    busy_d     = (state_d != ST_IDLE);
    err_d      = (state_d == ST_TRAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      alu_en_q   <= 1'b0;
      rf_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      alu_en_q   <= alu_en_d;
      rf_we_q    <= rf_we_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      instret_q  <= instret_d;
    end
  end

  // Handshake-dependent strobes are Mealy terms of the registered state
  assign dec_go   = fetch_ack_c;
  assign pc_we    = retire_c;
  assign pc_sel   = pc_sel_c;

  assign imem_req = imem_req_q;
  assign dmem_req = dmem_req_q;
  assign dmem_we  = dmem_we_q;
  assign alu_en   = alu_en_q;
  assign rf_we    = rf_we_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for riscv_mc_ctrl; covers the CTRL_TIMEOUT_EN build when that macro is defined.
module tb_riscv_mc_ctrl;
  import riscv_ctrl_pkg::*;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, halt_req, err_clr;
  logic [6:0]       opcode;
  logic             alu_instr, branch_instr, load_instr, store_instr, branch_taken;
  logic             imem_req, imem_ack, dec_go;
  logic             dmem_req, dmem_we, dmem_ack;
  logic             alu_en, rf_we, pc_we, pc_sel, busy, err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] instret;

  int checks   = 0;
  int failures = 0;

  riscv_mc_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .halt_req     (halt_req),
    .err_clr      (err_clr),
    .opcode       (opcode),
    .alu_instr    (alu_instr),
    .branch_instr (branch_instr),
    .load_instr   (load_instr),
    .store_instr  (store_instr),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .dec_go       (dec_go),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ack     (dmem_ack),
    .alu_en       (alu_en),
    .rf_we        (rf_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .busy         (busy),
    .err          (err),
    .err_code     (err_code),
    .instret      (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Move into the next cycle; inputs set after this belong to that cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; err_clr = 1'b0;
    opcode = OPC_INVALID; alu_instr = 1'b0; branch_instr = 1'b0;
    load_instr = 1'b0; store_instr = 1'b0; branch_taken = 1'b0;
    imem_ack = 1'b1; dmem_ack = 1'b1;

    // Reset state, with both acks high and ignored
    repeat (2) @(posedge clk);
    #3;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_dec_go", dec_go, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_instret", instret, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b0;

    // Run A: ALU, load (ack after 3 waits), store with halt on its retire
    tick();
    start = 1'b1; opcode = OPC_OP; alu_instr = 1'b1; imem_ack = 1'b1;
    settle();
    chk("a_idle_busy", busy, 0);
    chk("a_idle_ack_no_req", dec_go, 0);
    tick(); start = 1'b0; settle();
    chk("a_fetch_req", imem_req, 1);
    chk("a_fetch_dec_go", dec_go, 1);
    chk("a_fetch_busy", busy, 1);
    tick(); settle();
    chk("a_dec_req", imem_req, 0);
    chk("a_dec_go_low", dec_go, 0);
    chk("a_dec_alu_en", alu_en, 0);
    tick(); settle();
    chk("a_exec_alu_en", alu_en, 1);
    chk("a_exec_pc_we", pc_we, 0);
    tick(); settle();
    chk("a_wb_rf_we", rf_we, 1);
    chk("a_wb_pc_we", pc_we, 1);
    chk("a_wb_pc_sel", pc_sel, 0);
    chk("a_wb_instret", instret, 0);

    tick(); alu_instr = 1'b0; load_instr = 1'b1; opcode = OPC_LOAD; settle();
    chk("ld_fetch_instret", instret, 1);
    chk("ld_fetch_dec_go", dec_go, 1);
    tick(); settle();
    tick(); settle();
    chk("ld_exec_alu_en", alu_en, 1);
    chk("ld_exec_dmem_req", dmem_req, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); dmem_ack = (i == 3); settle();
      chk("ld_mem_req", dmem_req, 1);
      chk("ld_mem_we", dmem_we, 0);
      chk("ld_mem_pc_we", pc_we, 0);
      chk("ld_mem_rf_we", rf_we, 0);
      chk("ld_mem_dec_go", dec_go, 0);
    end
    tick(); dmem_ack = 1'b0; settle();
    chk("ld_wb_dmem_req", dmem_req, 0);
    chk("ld_wb_rf_we", rf_we, 1);
    chk("ld_wb_pc_we", pc_we, 1);

    tick(); load_instr = 1'b0; store_instr = 1'b1; opcode = OPC_STORE; settle();
    chk("st_fetch_instret", instret, 2);
    tick(); settle();
    tick(); settle();
    tick(); dmem_ack = 1'b1; halt_req = 1'b1; settle();
    chk("st_mem_req", dmem_req, 1);
    chk("st_mem_we", dmem_we, 1);
    chk("st_mem_pc_we", pc_we, 1);
    chk("st_mem_pc_sel", pc_sel, 0);
    chk("st_mem_rf_we", rf_we, 0);
    tick(); dmem_ack = 1'b0; halt_req = 1'b0; settle();
    chk("halt_busy", busy, 0);
    chk("halt_instret", instret, 3);
    chk("halt_rf_we", rf_we, 0);
    chk("halt_imem_req", imem_req, 0);

    // Run B: taken branch retires in EXEC, then fetch without any ack
    start = 1'b1; store_instr = 1'b0; branch_instr = 1'b1; branch_taken = 1'b1;
    opcode = OPC_BRANCH;
    tick(); start = 1'b0; settle();
    tick(); settle();
    tick(); settle();
    chk("br_exec_alu_en", alu_en, 1);
    chk("br_exec_pc_we", pc_we, 1);
    chk("br_exec_pc_sel", pc_sel, 1);
    chk("br_exec_rf_we", rf_we, 0);
    tick(); imem_ack = 1'b0; settle();
    chk("br_next_fetch", imem_req, 1);
    chk("br_next_rf_we", rf_we, 0);
    chk("br_instret", instret, 4);

`ifdef CTRL_TIMEOUT_EN
    for (int k = 2; k <= 16; k++) begin
      tick(); settle();
      chk("to_wait_req", imem_req, 1);
      chk("to_wait_err", err, 0);
    end
    tick(); settle();
    chk("to_trap_req", imem_req, 0);
    chk("to_trap_err", err, 1);
    chk("to_trap_code", err_code, 2);
    err_clr = 1'b1;
    tick(); err_clr = 1'b0; settle();
    chk("to_clr_err", err, 0);
    chk("to_clr_code", err_code, 0);
    chk("to_clr_busy", busy, 0);
    start = 1'b1; branch_instr = 1'b0; branch_taken = 1'b0; opcode = OPC_INVALID;
    tick(); start = 1'b0; settle();
    for (int k = 2; k <= 16; k++) begin
      tick(); imem_ack = (k == 16); settle();
    end
    chk("to_late_ack_go", dec_go, 1);
    tick(); imem_ack = 1'b0; settle();
    chk("to_late_ack_no_trap", err, 0);
    chk("to_late_ack_decode", busy, 1);
`else
    for (int k = 2; k <= 20; k++) begin
      tick(); settle();
      chk("wait_req", imem_req, 1);
      chk("wait_err", err, 0);
    end
    tick(); branch_instr = 1'b0; branch_taken = 1'b0; opcode = OPC_INVALID;
    imem_ack = 1'b1; settle();
    chk("late_ack_go", dec_go, 1);
    tick(); imem_ack = 1'b0; settle();
    chk("ill_dec_req", imem_req, 0);
    chk("ill_dec_err", err, 0);
`endif

    // Illegal opcode trap and its exit
    tick(); settle();
    chk("ill_trap_err", err, 1);
    chk("ill_trap_code", err_code, 1);
    chk("ill_trap_pc_we", pc_we, 0);
    chk("ill_trap_alu_en", alu_en, 0);
    chk("ill_trap_req", imem_req, 0);
    start = 1'b1;
    tick(); start = 1'b0; settle();
    chk("ill_trap_hold", err, 1);
    err_clr = 1'b1;
    tick(); err_clr = 1'b0; settle();
    chk("ill_clr_err", err, 0);
    chk("ill_clr_code", err_code, 0);
    chk("ill_clr_busy", busy, 0);
    chk("ill_clr_instret", instret, 4);

    // Reset asserted mid-MEM
    start = 1'b1; load_instr = 1'b1; opcode = OPC_LOAD; imem_ack = 1'b1;
    tick(); start = 1'b0; settle();
    tick(); imem_ack = 1'b0; settle();
    tick(); settle();
    tick(); settle();
    chk("rm_mem_req", dmem_req, 1);
    rst_n = 1'b0;
    settle();
    chk("rm_req_drop", dmem_req, 0);
    chk("rm_instret", instret, 0);
    chk("rm_busy", busy, 0);
    dmem_ack = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick(); settle();
    chk("rm_after_busy", busy, 0);
    chk("rm_after_instret", instret, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_mc_ctrl.md
Name: riscv_mc_ctrl

Overview:
Multicycle sequencer for the RV32 core. It steps each instruction through FETCH, DECODE, EXEC, optional MEM, and WB/retire.
- Pulses the decoder's `go` and consumes the decoder's class flags.
- Runs request/acknowledge handshakes to instruction and data memory.
- Generates the ALU, register-file and PC enables.
- Traps on illegal opcodes.

Parameters:
- CNT_W, 32, width of retired-instruction counter instret.
- TIMEOUT_CYC, 16, memory-ack timeout in cycles (used only with CTRL_TIMEOUT_EN).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  leave IDLE and begin fetching.
- halt_req  in  1  stop after the current instruction retires.
- err_clr  in  1  leave TRAP.
- opcode  in  7  decoder opcode; 0 means invalid.
- alu_instr, branch_instr, load_instr, store_instr  in  1 each  decoder class flags.
- branch_taken  in  1  branch comparison result from the ALU, valid in EXEC.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  instruction word valid at the decoder input.
- dec_go  out  1  decoder capture strobe.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_ack  in  1  data access complete.
- alu_en  out  1  ALU operand/result capture.
- rf_we  out  1  register-file write.
- pc_we  out  1  PC update.
- pc_sel  out  1  1 = branch target, 0 = PC+4.
- busy  out  1  state is not IDLE.
- err  out  1  sticky trap indication.
- err_code  out  2  0 none, 1 illegal opcode, 2 memory timeout.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (asynchronous, takes effect mid-operation):
  - state goes to IDLE.
  - All strobes/requests are 0, err = 0, err_code = 0, instret = 0.
  - No partial retire occurs.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Encoding is binary and defined in the package.
- IDLE:
  - busy = 0.
  - start = 1 moves to FETCH next cycle.
  - halt_req is ignored.
- FETCH:
  - imem_req = 1, held until imem_ack.
  - dec_go = imem_req & imem_ack, combinational; the decoder registers the instruction on that edge.
  - On ack, move to DECODE. There is no minimum wait; an ack in the first FETCH cycle is legal.
- DECODE:
  - Exactly one cycle, so the registered decoder outputs can settle.
  - opcode == 0 moves to TRAP with err_code = 1.
  - Otherwise move to EXEC.
- EXEC: alu_en = 1 for one cycle. Next state:
  - load_instr | store_instr: MEM.
  - branch_instr: retire here with pc_we = 1 and pc_sel = branch_taken.
  - Anything else: WB.
- MEM:
  - dmem_req = 1 and dmem_we = store_instr, held until dmem_ack.
  - Store with ack: retire in the ack cycle (pc_we = 1, pc_sel = 0).
  - Load with ack: move to WB.
- WB: rf_we = 1 and pc_we = 1, pc_sel = 0, for one cycle. This is the retire.
- Retire cycle:
  - instret increments by 1, wrapping modulo 2^CNT_W.
  - halt_req = 1 in this cycle gives next state IDLE; otherwise FETCH.
- Acks:
  - An ack while the corresponding req = 0 is ignored.
  - imem_ack and dmem_ack arriving together: only the one for the active state counts.
- TRAP:
  - err = 1; all requests and enables are 0.
  - Exits only on err_clr: state goes to IDLE and err/err_code clear.
  - err_clr outside TRAP has no effect.
- Timing: latency is at least 4 cycles for ALU/branch-free ops and at least 5 for loads, with zero-wait memory.

Optional Feature:
CTRL_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to FETCH/MEM and increments each cycle the request is pending.
  - Reaching TIMEOUT_CYC without an ack moves to TRAP with err_code = 2 and drops the request in the same cycle the state changes.
  - An ack in the same cycle the count reaches TIMEOUT_CYC wins; no trap.
- Undefined: no counter; the controller waits indefinitely and err_code = 2 is never produced.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - the ctrl_state_t enum.
  - the err_code_t localparams (ERR_NONE, ERR_ILLEGAL, ERR_TIMEOUT).
  - the RV32 opcode constants shared with the decoder.
- Optional sub-module ctrl_wait_timer: the timeout counter, instantiated only under CTRL_TIMEOUT_EN.

Test Plan:
- ALU instruction, zero-wait memory, start pulse: dec_go in cycle 1, alu_en in cycle 3, rf_we = pc_we = 1 in cycle 4, instret = 1.
- Load with dmem_ack delayed 3 cycles: dmem_req high for 4 cycles with dmem_we = 0, then one-cycle rf_we; no rf_we for a store, and pc_we is seen in the ack cycle.
- Branch with branch_taken = 1: pc_we = 1, pc_sel = 1 in EXEC, rf_we never asserted, next state FETCH.
- opcode = 0 after fetch: TRAP, err = 1, err_code = 1, no pc_we; err_clr returns to IDLE with err = 0.
- halt_req high during the retire of the 3rd instruction: busy falls the next cycle, instret = 3; rst_n pulled low mid-MEM: dmem_req drops immediately and instret = 0.
- CTRL_TIMEOUT_EN with TIMEOUT_CYC = 16 and imem_ack never asserted: TRAP after 16 request cycles with err_code = 2; an ack on cycle 16 gives no trap.
